// File: rtl/maq_bcd_mod.sv
// Two-digit BCD modulo counter stage (seconds/minutes/hours) with up/down counting,
// carry/borrow chaining, a SET adjust mode and a range-checked parallel load.
module maq_bcd_mod #(
    parameter int MODULUS   = 60,
    parameter int MSD_W     = 3,
    parameter int RESET_VAL = 0
) (
    input  logic             maqm_clock,
    input  logic             maqm_reset,
    input  logic             maqm_enable,
    input  logic             maqm_tick,
    input  logic             maqm_down,
    input  logic             maqm_set_mode,
    input  logic             maqm_set_inc,
    input  logic             maqm_set_dec,
    input  logic             maqm_load,
    input  logic [3:0]       maqm_load_lsd,
    input  logic [MSD_W-1:0] maqm_load_msd,
    output logic [3:0]       maqm_lsd,
    output logic [MSD_W-1:0] maqm_msd,
    output logic             maqm_carry,
    output logic             maqm_borrow,
    output logic             maqm_load_err,
    output logic             maqm_in_set
);

    // state   | meaning
    // ST_RUN  | counting on tick, carry/borrow emitted on wrap
    // ST_SET  | manual adjust via set_inc/set_dec, tick ignored, no carry/borrow
    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_SET = 1'b1;

    localparam logic [MSD_W-1:0] MAX_MSD = MSD_W'((MODULUS - 1) / 10);
    localparam logic [3:0]       MAX_LSD = 4'((MODULUS - 1) % 10);
    localparam logic [MSD_W-1:0] RST_MSD = MSD_W'(RESET_VAL / 10);
    localparam logic [3:0]       RST_LSD = 4'(RESET_VAL % 10);

    generate
        if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
            $error("maq_bcd_mod: MODULUS must be within 2..100");
        end
        if (((MODULUS - 1) / 10) >= (1 << MSD_W)) begin : g_bad_msd_w
            $error("maq_bcd_mod: MSD_W too narrow for MODULUS");
        end
        if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
            $error("maq_bcd_mod: RESET_VAL must be below MODULUS");
        end
    endgenerate

    logic [0:0]       state;
    logic             up_wrap, dn_wrap, load_valid;
    logic [3:0]       up_lsd, dn_lsd, nxt_lsd;
    logic [MSD_W-1:0] up_msd, dn_msd, nxt_msd;
    logic             nxt_carry, nxt_borrow, nxt_load_err;

    always_comb begin
        up_wrap = (maqm_msd == MAX_MSD) && (maqm_lsd == MAX_LSD);
        up_lsd  = maqm_lsd + 4'd1;
        up_msd  = maqm_msd;
        if (up_wrap) begin
            up_lsd = 4'd0;
            up_msd = '0;
        end else if (maqm_lsd == 4'd9) begin
            up_lsd = 4'd0;
            up_msd = maqm_msd + 1'b1;
        end
    end

    always_comb begin
        dn_wrap = (maqm_msd == '0) && (maqm_lsd == 4'd0);
        dn_lsd  = maqm_lsd - 4'd1;
        dn_msd  = maqm_msd;
        if (dn_wrap) begin
            dn_lsd = MAX_LSD;
            dn_msd = MAX_MSD;
        end else if (maqm_lsd == 4'd0) begin
            dn_lsd = 4'd9;
            dn_msd = maqm_msd - 1'b1;
        end
    end

    // Equivalent to 10*msd + lsd < MODULUS once lsd is known to be a BCD digit.
    assign load_valid = (maqm_load_lsd <= 4'd9) &&
                        ((maqm_load_msd < MAX_MSD) ||
                         ((maqm_load_msd == MAX_MSD) && (maqm_load_lsd <= MAX_LSD)));

    always_comb begin
        nxt_lsd      = maqm_lsd;
        nxt_msd      = maqm_msd;
        nxt_carry    = 1'b0;
        nxt_borrow   = 1'b0;
        nxt_load_err = 1'b0;
        if (maqm_enable) begin
            if (maqm_load) begin
                if (load_valid) begin
                    nxt_lsd = maqm_load_lsd;
                    nxt_msd = maqm_load_msd;
                end else begin
                    nxt_load_err = 1'b1;
                end
            end else if (state == ST_SET) begin
                if (maqm_set_inc && !maqm_set_dec) begin
                    nxt_lsd = up_lsd;
                    nxt_msd = up_msd;
                end else if (maqm_set_dec && !maqm_set_inc) begin
                    nxt_lsd = dn_lsd;
                    nxt_msd = dn_msd;
                end
            end else if (maqm_tick) begin
                if (!maqm_down) begin
                    nxt_lsd   = up_lsd;
                    nxt_msd   = up_msd;
                    nxt_carry = up_wrap;
                end else begin
                    nxt_lsd    = dn_lsd;
                    nxt_msd    = dn_msd;
                    nxt_borrow = dn_wrap;
                end
            end
        end
    end

    always_ff @(posedge maqm_clock or negedge maqm_reset) begin
        if (!maqm_reset) begin
            state         <= ST_RUN;
            maqm_lsd      <= RST_LSD;
            maqm_msd      <= RST_MSD;
            maqm_carry    <= 1'b0;
            maqm_borrow   <= 1'b0;
            maqm_load_err <= 1'b0;
        end else begin
            state         <= maqm_set_mode ? ST_SET : ST_RUN;
            maqm_lsd      <= nxt_lsd;
            maqm_msd      <= nxt_msd;
            maqm_carry    <= nxt_carry;
            maqm_borrow   <= nxt_borrow;
            maqm_load_err <= nxt_load_err;
        end
    end

    assign maqm_in_set = (state == ST_SET);

endmodule

// File: tb/tb_maq_bcd_mod.sv
// Directed bench for maq_bcd_mod: a MODULUS=60 instance plus a MODULUS=24 instance
// sharing the same stimulus.
module tb_maq_bcd_mod;

    logic       maqm_clock = 1'b0;
    logic       maqm_reset = 1'b0;
    logic       enable = 1'b0, tick = 1'b0, down = 1'b0;
    logic       set_mode = 1'b0, set_inc = 1'b0, set_dec = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_lsd = 4'd0;
    logic [2:0] load_msd = 3'd0;

    logic [3:0] lsd, lsd24;
    logic [2:0] msd;
    logic [1:0] msd24;
    logic       carry, borrow, load_err, in_set;
    logic       carry24, borrow24, load_err24, in_set24;

    int checks = 0;
    int errors = 0;

    always #5 maqm_clock = ~maqm_clock;

    maq_bcd_mod #(.MODULUS(60), .MSD_W(3), .RESET_VAL(0)) dut (
        .maqm_clock(maqm_clock), .maqm_reset(maqm_reset), .maqm_enable(enable),
        .maqm_tick(tick), .maqm_down(down), .maqm_set_mode(set_mode),
        .maqm_set_inc(set_inc), .maqm_set_dec(set_dec), .maqm_load(load),
        .maqm_load_lsd(load_lsd), .maqm_load_msd(load_msd),
        .maqm_lsd(lsd), .maqm_msd(msd), .maqm_carry(carry), .maqm_borrow(borrow),
        .maqm_load_err(load_err), .maqm_in_set(in_set)
    );

    maq_bcd_mod #(.MODULUS(24), .MSD_W(2), .RESET_VAL(0)) dut24 (
        .maqm_clock(maqm_clock), .maqm_reset(maqm_reset), .maqm_enable(enable),
        .maqm_tick(tick), .maqm_down(down), .maqm_set_mode(set_mode),
        .maqm_set_inc(set_inc), .maqm_set_dec(set_dec), .maqm_load(load),
        .maqm_load_lsd(load_lsd), .maqm_load_msd(load_msd[1:0]),
        .maqm_lsd(lsd24), .maqm_msd(msd24), .maqm_carry(carry24), .maqm_borrow(borrow24),
        .maqm_load_err(load_err24), .maqm_in_set(in_set24)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge maqm_clock);
    endtask

    task automatic do_load(input logic [2:0] m, input logic [3:0] l);
        load = 1'b1; load_msd = m; load_lsd = l;
        cyc();
        load = 1'b0;
    endtask

    task automatic test_reset();
        maqm_reset = 1'b0;
        #2;
        checks++;
        if ({msd, lsd} !== {3'd0, 4'd0}) begin errors++; $display("FAIL reset_value: got %0d%0d want 00", msd, lsd); end
        checks++;
        if ({carry, borrow, load_err, in_set} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got c%b b%b e%b s%b want all 0", carry, borrow, load_err, in_set);
        end
        checks++;
        if ({msd24, lsd24} !== {2'd0, 4'd0}) begin errors++; $display("FAIL reset_value24: got %0d%0d want 00", msd24, lsd24); end
        cyc();
        maqm_reset = 1'b1;
        enable = 1'b1;
        cyc();
    endtask

    task automatic test_up_wrap();
        tick = 1'b1; down = 1'b0;
        for (int i = 1; i <= 59; i++) begin
            cyc();
            checks++;
            if (carry !== 1'b0) begin errors++; $display("FAIL up_no_carry_%0d: got %b want 0", i, carry); end
        end
        checks++;
        if ({msd, lsd} !== {3'd5, 4'd9}) begin errors++; $display("FAIL up_59: got %0d%0d want 59", msd, lsd); end
        cyc();
        tick = 1'b0;
        checks++;
        if ({msd, lsd, carry} !== {3'd0, 4'd0, 1'b1}) begin
            errors++; $display("FAIL up_wrap: got %0d%0d carry %b want 00 carry 1", msd, lsd, carry);
        end
        cyc();
        checks++;
        if ({msd, lsd, carry} !== {3'd0, 4'd0, 1'b0}) begin
            errors++; $display("FAIL up_carry_clear: got %0d%0d carry %b want 00 carry 0", msd, lsd, carry);
        end
    endtask

    task automatic test_down();
        tick = 1'b1; down = 1'b1;
        cyc();
        checks++;
        if ({msd, lsd, borrow, carry} !== {3'd5, 4'd9, 1'b1, 1'b0}) begin
            errors++; $display("FAIL down_wrap: got %0d%0d borrow %b carry %b want 59 borrow 1 carry 0", msd, lsd, borrow, carry);
        end
        cyc();
        tick = 1'b0; down = 1'b0;
        checks++;
        if ({msd, lsd, borrow} !== {3'd5, 4'd8, 1'b0}) begin
            errors++; $display("FAIL down_58: got %0d%0d borrow %b want 58 borrow 0", msd, lsd, borrow);
        end
    endtask

    task automatic test_mod24();
        do_load(3'd0, 4'd9);
        checks++;
        if ({msd24, lsd24} !== {2'd0, 4'd9}) begin errors++; $display("FAIL m24_load09: got %0d%0d want 09", msd24, lsd24); end
        tick = 1'b1; cyc(); tick = 1'b0;
        checks++;
        if ({msd24, lsd24} !== {2'd1, 4'd0}) begin errors++; $display("FAIL m24_09_to_10: got %0d%0d want 10", msd24, lsd24); end
        do_load(3'd2, 4'd3);
        tick = 1'b1; cyc(); tick = 1'b0;
        checks++;
        if ({msd24, lsd24, carry24} !== {2'd0, 4'd0, 1'b1}) begin
            errors++; $display("FAIL m24_up_wrap: got %0d%0d carry %b want 00 carry 1", msd24, lsd24, carry24);
        end
        tick = 1'b1; down = 1'b1; cyc(); tick = 1'b0; down = 1'b0;
        checks++;
        if ({msd24, lsd24, borrow24, carry24} !== {2'd2, 4'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL m24_down_wrap: got %0d%0d borrow %b carry %b want 23 borrow 1 carry 0", msd24, lsd24, borrow24, carry24);
        end
    endtask

    task automatic test_set();
        do_load(3'd5, 4'd7);
        // The tick in the mode-change cycle is still handled by RUN.
        set_mode = 1'b1; tick = 1'b1;
        cyc();
        checks++;
        if ({in_set, msd, lsd} !== {1'b1, 3'd5, 4'd8}) begin
            errors++; $display("FAIL set_enter: got in_set %b %0d%0d want in_set 1 58", in_set, msd, lsd);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({msd, lsd} !== {3'd5, 4'd8}) begin errors++; $display("FAIL set_tick_ignored_%0d: got %0d%0d want 58", i, msd, lsd); end
        end
        set_inc = 1'b1;
        cyc();
        checks++;
        if ({msd, lsd, carry} !== {3'd5, 4'd9, 1'b0}) begin errors++; $display("FAIL set_inc_59: got %0d%0d carry %b want 59 carry 0", msd, lsd, carry); end
        cyc();
        checks++;
        if ({msd, lsd, carry} !== {3'd0, 4'd0, 1'b0}) begin errors++; $display("FAIL set_inc_00: got %0d%0d carry %b want 00 carry 0", msd, lsd, carry); end
        cyc();
        checks++;
        if ({msd, lsd, carry} !== {3'd0, 4'd1, 1'b0}) begin errors++; $display("FAIL set_inc_01: got %0d%0d carry %b want 01 carry 0", msd, lsd, carry); end
        set_dec = 1'b1;
        cyc();
        set_inc = 1'b0;
        checks++;
        if ({msd, lsd} !== {3'd0, 4'd1}) begin errors++; $display("FAIL set_inc_dec: got %0d%0d want 01", msd, lsd); end
        cyc(); cyc();
        set_dec = 1'b0;
        checks++;
        if ({msd, lsd, borrow} !== {3'd5, 4'd9, 1'b0}) begin errors++; $display("FAIL set_dec_wrap: got %0d%0d borrow %b want 59 borrow 0", msd, lsd, borrow); end
        set_mode = 1'b0; tick = 1'b0;
        cyc();
        checks++;
        if ({in_set, msd, lsd} !== {1'b0, 3'd5, 4'd9}) begin
            errors++; $display("FAIL set_exit: got in_set %b %0d%0d want in_set 0 59", in_set, msd, lsd);
        end
    endtask

    task automatic test_load();
        do_load(3'd4, 4'd7);
        checks++;
        if ({msd, lsd, load_err} !== {3'd4, 4'd7, 1'b0}) begin errors++; $display("FAIL load_47: got %0d%0d err %b want 47 err 0", msd, lsd, load_err); end
        do_load(3'd4, 4'd10);
        checks++;
        if ({msd, lsd, load_err} !== {3'd4, 4'd7, 1'b1}) begin errors++; $display("FAIL load_lsd10: got %0d%0d err %b want 47 err 1", msd, lsd, load_err); end
        cyc();
        checks++;
        if (load_err !== 1'b0) begin errors++; $display("FAIL load_err_clear: got %b want 0", load_err); end
        do_load(3'd6, 4'd0);
        checks++;
        if ({msd, lsd, load_err} !== {3'd4, 4'd7, 1'b1}) begin errors++; $display("FAIL load_60: got %0d%0d err %b want 47 err 1", msd, lsd, load_err); end
        do_load(3'd5, 4'd9);
        tick = 1'b1;
        do_load(3'd1, 4'd2);
        tick = 1'b0;
        checks++;
        if ({msd, lsd, carry} !== {3'd1, 4'd2, 1'b0}) begin errors++; $display("FAIL load_over_tick: got %0d%0d carry %b want 12 carry 0", msd, lsd, carry); end
    endtask

    task automatic test_enable();
        enable = 1'b0; tick = 1'b1;
        cyc(); cyc();
        checks++;
        if ({msd, lsd, carry} !== {3'd1, 4'd2, 1'b0}) begin errors++; $display("FAIL enable_hold: got %0d%0d carry %b want 12 carry 0", msd, lsd, carry); end
        tick = 1'b0;
        do_load(3'd7, 4'd15);
        checks++;
        if ({msd, lsd, load_err} !== {3'd1, 4'd2, 1'b0}) begin errors++; $display("FAIL enable_load_ignored: got %0d%0d err %b want 12 err 0", msd, lsd, load_err); end
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        do_load(3'd5, 4'd9);
        tick = 1'b1; cyc(); tick = 1'b0;
        checks++;
        if ({msd, lsd, carry} !== {3'd0, 4'd0, 1'b1}) begin errors++; $display("FAIL ar_setup: got %0d%0d carry %b want 00 carry 1", msd, lsd, carry); end
        #2 maqm_reset = 1'b0;
        #1;
        checks++;
        if ({msd, lsd, carry, in_set} !== {3'd0, 4'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL ar_carry_clear: got %0d%0d carry %b in_set %b want 00 carry 0 in_set 0", msd, lsd, carry, in_set);
        end
        cyc();
        maqm_reset = 1'b1;
        tick = 1'b1; cyc(); tick = 1'b0;
        checks++;
        if ({msd, lsd, in_set} !== {3'd0, 4'd1, 1'b0}) begin errors++; $display("FAIL ar_resume: got %0d%0d in_set %b want 01 in_set 0", msd, lsd, in_set); end
        do_load(3'd4, 4'd7);
        #2 maqm_reset = 1'b0;
        #1;
        checks++;
        if ({msd, lsd} !== {3'd0, 4'd0}) begin errors++; $display("FAIL ar_midcycle: got %0d%0d want 00", msd, lsd); end
        cyc();
        maqm_reset = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down();
        test_mod24();
        test_set();
        test_load();
        test_enable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
